linear_regression_training: RTL
===============================

Name: linear_regression_training

Overview:
- Fits a least-squares line to a batch of N_SAMPLES (x, y) points and produces theta0 (intercept) and theta1 (slope).
- It is the producer side of the theta interface that linear_regression_prediction consumes: i_theta0_out, i_theta1_out and i_theta1_out_vld on the predictor are driven by this block.
- It accumulates sums, then computes the closed-form solution with one sequential divider.

Parameters:
- DATA_W, 16, width of the unsigned x and y samples.
- LOG2_N, 7, log2 of batch size; N_SAMPLES = 2**LOG2_N.
- THETA_W, 32, width of the signed theta outputs.
- Localparam W_PROD = 2*(DATA_W+LOG2_N)+2, the signed width used for numerator, denominator and divider.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_samples_x_in  in  DATA_W  unsigned x.
- i_samples_y_in  in  DATA_W  unsigned y.
- i_samples_vld  in  1  sample valid.
- o_samples_rdy  out  1  block can accept a sample.
- o_theta0_out  out  THETA_W  signed intercept.
- o_theta1_out  out  THETA_W  signed slope.
- o_theta1_out_vld  out  1  theta pair valid (level).
- o_theta_update  out  1  one-cycle pulse when a new theta pair is loaded.
- o_degenerate  out  1  last batch had zero denominator.

Behaviour:
- Reset (async, mid-operation included): aborts any batch or divide and clears all sums and counter.
  - State = ACCUM, o_samples_rdy=1.
  - o_theta0_out=0, o_theta1_out=0, o_theta1_out_vld=0, o_theta_update=0, o_degenerate=0.
- Handshake: a sample is accepted on a rising edge with i_samples_vld && o_samples_rdy. o_samples_rdy is 1 only in ACCUM. A valid asserted while rdy=0 is ignored; it is neither buffered nor counted.
- ACCUM: on each accepted sample, update Sx+=x, Sy+=y, Sxy+=x*y, Sxx+=x*x and cnt+=1.
  - Widths are sized so no overflow is possible for N_SAMPLES samples.
  - When the accepted sample is number N_SAMPLES, go to MUL1. cnt wraps to 0.
- MUL1: num = N*Sxy - Sx*Sy; den = N*Sxx - Sx*Sx. Both are signed W_PROD. Multiplication by N is a shift left by LOG2_N.
- MUL2: if den==0, set theta1q=0 and deg=1, then go to THETA0. Otherwise load the divider and go to DIV.
- DIV: the sub-module performs signed division truncating toward zero and takes exactly W_PROD cycles; its done pulse moves the FSM to THETA0. The quotient is saturated to the signed THETA_W range.
- THETA0: t0 = (Sy - theta1q*Sx) >>> LOG2_N, an arithmetic shift (floor), saturated to THETA_W. Then go to LOAD.
- LOAD (one cycle):
  - o_theta0_out, o_theta1_out and o_degenerate update in the same edge.
  - o_theta_update pulses high for one cycle.
  - o_theta1_out_vld is set to 1 and stays 1 until reset.
  - Sums are cleared and the FSM returns to ACCUM with o_samples_rdy=1.
- Latency: if the last sample is accepted at edge t, o_theta_update is high in the cycle after edge t+W_PROD+4.
  - This holds in the non-degenerate case.
  - In the degenerate case the latency is W_PROD cycles shorter.
- Old theta values remain on the outputs, still valid, while the next batch trains. This lets the predictor run continuously.

Decomposition:
- Shared package linear_regression_pkg holds:
  - DATA_W, THETA_W and LOG2_N defaults;
  - the FSM state enum (ACCUM, MUL1, MUL2, DIV, THETA0, LOAD);
  - the saturate-to-THETA_W function.
- One sub-module, lr_seq_divider: signed restoring divider, parameter W, ports i_start/i_num/i_den/o_done/o_quot, W-cycle latency, truncation toward zero.
- All other logic lives in the top module.

Test Plan (LOG2_N=2, so N=4, unless stated):
- x=1,2,3,4 with y=7,9,11,13 -> theta1=2, theta0=5, degenerate=0, one o_theta_update pulse at the specified latency, vld=1.
- x=1,2,3,4 with y=17,14,11,8 -> theta1=-3, theta0=20.
- x=3,3,3,3 with y=1,2,3,4 -> degenerate=1, theta1=0, theta0=2 (10>>>2).
- x=1..4 with y=0,0,0,1 -> num=6, den=20, theta1=0 (truncated), theta0=0.
- Hold i_samples_vld=1 through the compute window with junk values, then send a valid batch -> junk is not counted; rdy=0 during compute; the second batch result is correct; the first theta pair stays on the outputs until LOAD.
- Assert reset in the middle of DIV, then send batch 1 -> all outputs reset to 0 and vld=0; the following batch yields theta1=2, theta0=5 with no residue from the aborted batch.

Source files
------------

// File: rtl/linear_regression_pkg.sv
// rtl/linear_regression_pkg.sv - shared defaults, FSM states and theta saturation for the regression trainer
package linear_regression_pkg;

  localparam int DATA_W_DEFAULT  = 16;
  localparam int LOG2_N_DEFAULT  = 7;
  localparam int THETA_W_DEFAULT = 32;
  localparam int SAT_W           = 128;

  typedef enum logic [2:0] {
    ACCUM,
    MUL1,
    MUL2,
    DIV,
    THETA0,
    LOAD
  } lr_state_t;

  // Clamp a wide signed value to the signed range of a w-bit result.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = {{(SAT_W-1){1'b0}}, 1'b1} << (w - 1);
    max_v = max_v - 1;
    min_v = ~max_v;
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/linear_regression_training_divider.sv
// rtl/linear_regression_training_divider.sv - signed restoring divider, W-cycle latency, truncates toward zero
module lr_seq_divider #(
  parameter int W = 48
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic signed [W-1:0] i_num,
  input  logic signed [W-1:0] i_den,
  output logic                o_done,
  output logic signed [W-1:0] o_quot
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     den_q;
  logic             neg_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W-1:0] num_abs;
  logic [W-1:0] den_abs;
  logic [W-1:0] step_rem_in;
  logic [W-1:0] step_quo_in;
  logic [W-1:0] step_den;
  logic [W-1:0] step_rem;
  logic [W-1:0] step_quo;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // The start cycle already performs the first iteration on the fresh
  // operands, so W iterations finish W cycles after i_start.
  always_comb begin
    num_abs     = i_num[W-1] ? -i_num : i_num;
    den_abs     = i_den[W-1] ? -i_den : i_den;
    step_rem_in = i_start ? '0 : rem_q;
    step_quo_in = i_start ? num_abs : quo_q;
    step_den    = i_start ? den_abs : den_q;
    shifted     = {step_rem_in, step_quo_in[W-1]};
    diff        = shifted - {1'b0, step_den};
    if (!diff[W]) begin
      step_rem = diff[W-1:0];
      step_quo = {step_quo_in[W-2:0], 1'b1};
    end else begin
      step_rem = shifted[W-1:0];
      step_quo = {step_quo_in[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        rem_q  <= step_rem;
        quo_q  <= step_quo;
        den_q  <= den_abs;
        neg_q  <= i_num[W-1] ^ i_den[W-1];
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(1);
      end else if (busy_q) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          busy_q <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_quot = neg_q ? -quo_q : quo_q;

endmodule

// File: rtl/linear_regression_training.sv
// rtl/linear_regression_training.sv - batch least-squares line fit producing theta0/theta1 for the predictor
module linear_regression_training
  import linear_regression_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int LOG2_N  = LOG2_N_DEFAULT,
  parameter int THETA_W = THETA_W_DEFAULT
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [DATA_W-1:0]         i_samples_x_in,
  input  logic [DATA_W-1:0]         i_samples_y_in,
  input  logic                      i_samples_vld,
  output logic                      o_samples_rdy,
  output logic signed [THETA_W-1:0] o_theta0_out,
  output logic signed [THETA_W-1:0] o_theta1_out,
  output logic                      o_theta1_out_vld,
  output logic                      o_theta_update,
  output logic                      o_degenerate
);

  localparam int W_PROD = 2 * (DATA_W + LOG2_N) + 2;
  localparam int SX_W   = DATA_W + LOG2_N;
  localparam int SXX_W  = 2 * DATA_W + LOG2_N;
  localparam int T0_W   = THETA_W + DATA_W + LOG2_N + 2;

  lr_state_t state_q;
  lr_state_t state_d;

  logic [SX_W-1:0]           sx_q;
  logic [SX_W-1:0]           sy_q;
  logic [SXX_W-1:0]          sxy_q;
  logic [SXX_W-1:0]          sxx_q;
  logic [LOG2_N-1:0]         cnt_q;
  logic signed [W_PROD-1:0]  num_q;
  logic signed [W_PROD-1:0]  den_q;
  logic signed [THETA_W-1:0] theta1_q;
  logic signed [THETA_W-1:0] theta0_q;
  logic                      deg_q;

  logic                      accept;
  logic                      div_start;
  logic                      div_done;
  logic signed [W_PROD-1:0]  div_quot;
  logic [2*DATA_W-1:0]       xy;
  logic [2*DATA_W-1:0]       xx;
  logic [W_PROD-1:0]         sx_w;
  logic [W_PROD-1:0]         sy_w;
  logic [W_PROD-1:0]         sxy_w;
  logic [W_PROD-1:0]         sxx_w;
  logic [W_PROD-1:0]         num_c;
  logic [W_PROD-1:0]         den_c;
  logic signed [T0_W-1:0]    sx_ext;
  logic signed [T0_W-1:0]    sy_ext;
  logic signed [T0_W-1:0]    t1_ext;
  logic signed [T0_W-1:0]    t0_full;
  logic signed [T0_W-1:0]    t0_shift;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    o_samples_rdy = 1'b0;
    div_start     = 1'b0;
    case (state_q)
      ACCUM: begin
        o_samples_rdy = 1'b1;
        if (i_samples_vld && cnt_q == '1) begin
          state_d = MUL1;
        end
      end
      MUL1: state_d = MUL2;
      MUL2: begin
        if (den_q == '0) begin
          state_d = THETA0;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = THETA0;
        end
      end
      THETA0:  state_d = LOAD;
      LOAD:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  assign accept = i_samples_vld && o_samples_rdy;

  // Products are formed at full width so N*S - S*S cannot wrap.
  always_comb begin
    xy    = i_samples_x_in * i_samples_y_in;
    xx    = i_samples_x_in * i_samples_x_in;
    sx_w  = W_PROD'(sx_q);
    sy_w  = W_PROD'(sy_q);
    sxy_w = W_PROD'(sxy_q);
    sxx_w = W_PROD'(sxx_q);
    num_c = (sxy_w << LOG2_N) - sx_w * sy_w;
    den_c = (sxx_w << LOG2_N) - sx_w * sx_w;
  end

  always_comb begin
    sx_ext   = $signed({{(T0_W-SX_W){1'b0}}, sx_q});
    sy_ext   = $signed({{(T0_W-SX_W){1'b0}}, sy_q});
    t1_ext   = $signed({{(T0_W-THETA_W){theta1_q[THETA_W-1]}}, theta1_q});
    t0_full  = sy_ext - t1_ext * sx_ext;
    t0_shift = t0_full >>> LOG2_N;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sx_q             <= '0;
      sy_q             <= '0;
      sxy_q            <= '0;
      sxx_q            <= '0;
      cnt_q            <= '0;
      num_q            <= '0;
      den_q            <= '0;
      theta1_q         <= '0;
      theta0_q         <= '0;
      deg_q            <= 1'b0;
      o_theta0_out     <= '0;
      o_theta1_out     <= '0;
      o_theta1_out_vld <= 1'b0;
      o_theta_update   <= 1'b0;
      o_degenerate     <= 1'b0;
    end else begin
      o_theta_update <= 1'b0;
      if (accept) begin
        sx_q  <= sx_q + SX_W'(i_samples_x_in);
        sy_q  <= sy_q + SX_W'(i_samples_y_in);
        sxy_q <= sxy_q + SXX_W'(xy);
        sxx_q <= sxx_q + SXX_W'(xx);
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        MUL1: begin
          num_q <= $signed(num_c);
          den_q <= $signed(den_c);
        end
        MUL2: begin
          deg_q <= (den_q == '0);
          if (den_q == '0) begin
            theta1_q <= '0;
          end
        end
        DIV: begin
          if (div_done) begin
            theta1_q <= THETA_W'(saturate({{(SAT_W-W_PROD){div_quot[W_PROD-1]}}, div_quot}, THETA_W));
          end
        end
        THETA0: begin
          theta0_q <= THETA_W'(saturate({{(SAT_W-T0_W){t0_shift[T0_W-1]}}, t0_shift}, THETA_W));
        end
        LOAD: begin
          o_theta0_out     <= theta0_q;
          o_theta1_out     <= theta1_q;
          o_degenerate     <= deg_q;
          o_theta1_out_vld <= 1'b1;
          o_theta_update   <= 1'b1;
          sx_q             <= '0;
          sy_q             <= '0;
          sxy_q            <= '0;
          sxx_q            <= '0;
          cnt_q            <= '0;
        end
        default: ;
      endcase
    end
  end

  lr_seq_divider #(
    .W(W_PROD)
  ) u_divider (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (div_start),
    .i_num   (num_q),
    .i_den   (den_q),
    .o_done  (div_done),
    .o_quot  (div_quot)
  );

endmodule
